acx_eth_stream_upsizer: RTL and testbench
=========================================

// Module: acx_eth_stream_upsizer
// PURPOSE
//  Parametrised width upsizer for Ethernet streams: packs a narrow IN_WIDTH t_ETH_STREAM into the 256-bit NAP
//  Ethernet stream (ACX_NAP_ETH_DATA_WIDTH) with numeric mod, SOP timestamp and EOP flags carried across.
//  Sits between user packet logic running a narrow datapath and the Ethernet NAP TX side.
//  Successor to fixed-width passthrough: generalised ratio, protocol-error recovery, optional statistics.
// PARAMETERS
//  IN_WIDTH    64                      input data width; 32/64/128; OUT_WIDTH/IN_WIDTH power of 2, >=2
//  OUT_WIDTH   `ACX_NAP_ETH_DATA_WIDTH output data width (256)
//  ADDR_WIDTH  `ACX_NAP_DS_ADDR_WIDTH  stream address width (4)
// PORTS
//  i_clk        in   1   clock; all logic single clock domain
//  i_reset      in   1   synchronous, active-high reset
//  if_in        rx   t_ETH_STREAM #(IN_WIDTH, $clog2(IN_WIDTH/8))   narrow input stream
//  if_out       tx   t_ETH_STREAM #(OUT_WIDTH, `ACX_NAP_ETH_MOD_WIDTH) NAP-width output stream
//  o_proto_err  out  1   one-cycle pulse: SOP received while packet open
//  o_pkt_count  out  32  packets emitted (stats)
//  o_err_count  out  16  protocol errors seen (stats)
// BEHAVIOUR
//  - RATIO=OUT_WIDTH/IN_WIDTH, IN_BYTES=IN_WIDTH/8. Mod numeric; 0 = all lanes valid (both sides).
//  - Lane packing little-endian: packet beat k of an output word lands at bits [k*IN_WIDTH +: IN_WIDTH].
//  - Accumulator + lane index idx (0..RATIO-1) + single output holding register.
//  - Input transfer: if_in.valid & if_in.ready. if_in.ready = ~if_out.valid | if_out.ready (comb).
//  - Output word completes when idx==RATIO-1 accepted or EOP beat accepted; word loads output register the
//    same edge; if_out.valid asserts next cycle (latency 1 from completing beat). idx returns to 0.
//  - Output held stable while valid & ~ready; no change to data/mod/flags/sop/eop until accepted.
//  - Output mod: non-EOP word = 0; EOP word = (idx*IN_BYTES + (in.mod==0 ? IN_BYTES : in.mod)) mod 32.
//  - Lanes above last valid byte of EOP word driven 0.
//  - if_out.sop = first word of packet; if_out.eop = word containing input EOP; sop&eop allowed together.
//  - addr and timestamp captured on input SOP beat; presented on output SOP word.
//  - flags: output EOP word carries flags of input EOP beat; non-EOP words flags = flags of last beat in word.
//  - States: IDLE (no packet open) -> PKT on SOP accept; PKT -> IDLE on EOP accept.
//  - Beat accepted in IDLE without SOP: dropped, o_proto_err pulse.
//  - SOP accepted in PKT: partial word discarded (nothing emitted), o_proto_err pulse, new packet starts at idx 0.
//  - SOP and EOP on same input beat: single output word, sop=eop=1.
//  - Reset: if_out.valid=0, sop=eop=0, data/mod/flags/timestamp/addr=0, idx=0, state IDLE,
//    o_proto_err=0, counters 0. Reset mid-packet discards partial word and any unaccepted output.
// CONFIGURATION
//  ACX_ETH_UPSIZER_STATS_EN defined: o_pkt_count increments on each accepted output EOP word;
//    o_err_count increments on each o_proto_err pulse; both saturate at all-ones.
//  Not defined: counter logic not built; o_pkt_count/o_err_count tied 0; ports remain present.
// STRUCTURE
//  Package acx_eth_upsizer_pkg: RATIO/IN_BYTES calc functions, state enum (IDLE, PKT),
//    eop mod calc function; t_ETH_FLAG_UNION/t_ETH_STREAM taken from NAP interface include.
//  Sub-module acx_eth_upsizer_oreg: output holding register with valid/ready; top keeps accumulator + FSM.
// TESTING (IN_WIDTH=64, RATIO=4, IN_BYTES=8)
//  1 64B packet, 8 beats, mod 0, out_ready=1 -> 2 words: w0 sop=1 mod 0, w1 eop=1 mod 0; no in_ready stall.
//  2 13B packet: beat0 full, beat1 eop mod 5 -> 1 word sop=eop=1, mod 13, bytes 13..31 = 0.
//  3 32B packet, beat3 eop mod 0 -> 1 word mod 0, sop=eop=1; next packet starts at lane 0.
//  4 Random out_ready (50%), 100 pkts of 1..1500B -> scoreboard byte-exact, no loss/duplication.
//  5 SOP after 2 beats of open packet -> o_proto_err 1-cycle pulse, partial dropped, new packet exact;
//    with STATS_EN o_err_count=1.
//  6 timestamp 0x1234567, addr 0xF on SOP, flags.tx.crc_insert=1 on EOP -> out SOP word ts 0x1234567,
//    addr 0xF; EOP word crc_insert=1; reset asserted mid-packet -> valid=0 next cycle, later packet exact.

Source files
------------

// File: rtl/acx_eth_upsizer_pkg.sv
// Shared types, NAP width defaults and helper functions for the Ethernet stream upsizer.
`ifndef ACX_NAP_ETH_DATA_WIDTH
`define ACX_NAP_ETH_DATA_WIDTH 256
`endif
`ifndef ACX_NAP_ETH_MOD_WIDTH
`define ACX_NAP_ETH_MOD_WIDTH 5
`endif
`ifndef ACX_NAP_DS_ADDR_WIDTH
`define ACX_NAP_DS_ADDR_WIDTH 4
`endif

package acx_eth_upsizer_pkg;

  localparam int ETH_TS_WIDTH = 32;

  typedef struct packed {
    logic [6:0] reserved;
    logic       crc_insert;
  } t_ETH_TX_FLAGS;

  typedef struct packed {
    logic [5:0] reserved;
    logic       crc_error;
    logic       length_error;
  } t_ETH_RX_FLAGS;

  typedef union packed {
    t_ETH_TX_FLAGS tx;
    t_ETH_RX_FLAGS rx;
  } t_ETH_FLAG_UNION;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } upsz_state_e;

  function automatic int calc_ratio(input int in_width, input int out_width);
    return out_width / in_width;
  endfunction

  function automatic int calc_in_bytes(input int in_width);
    return in_width / 8;
  endfunction

  // Byte count of the closing word, wrapped so a completely full word reads as 0.
  function automatic int calc_eop_mod(input int idx, input int in_mod, input int in_bytes,
                                      input int out_bytes);
    int valid_bytes;
    valid_bytes = (in_mod == 0) ? in_bytes : in_mod;
    return (idx * in_bytes + valid_bytes) % out_bytes;
  endfunction

endpackage

// File: rtl/acx_eth_nap_if.sv
// Ethernet stream interface (NAP style): data, numeric mod, sop/eop, timestamp, addr and flags.
interface t_ETH_STREAM #(
  parameter int DATA_WIDTH = `ACX_NAP_ETH_DATA_WIDTH,
  parameter int MOD_WIDTH  = `ACX_NAP_ETH_MOD_WIDTH
);
  import acx_eth_upsizer_pkg::*;

  logic                             valid;
  logic                             ready;
  logic                             sop;
  logic                             eop;
  logic [DATA_WIDTH-1:0]            data;
  logic [MOD_WIDTH-1:0]             mod;
  logic [ETH_TS_WIDTH-1:0]          timestamp;
  logic [`ACX_NAP_DS_ADDR_WIDTH-1:0] addr;
  t_ETH_FLAG_UNION                  flags;

  modport tx (output valid, sop, eop, data, mod, timestamp, addr, flags, input ready);
  modport rx (input valid, sop, eop, data, mod, timestamp, addr, flags, output ready);
endinterface

// File: rtl/acx_eth_upsizer_oreg.sv
// Output holding register for the upsizer: one word, held stable until the sink accepts it.
module acx_eth_upsizer_oreg
  import acx_eth_upsizer_pkg::*;
#(
  parameter int DATA_WIDTH = `ACX_NAP_ETH_DATA_WIDTH,
  parameter int MOD_WIDTH  = `ACX_NAP_ETH_MOD_WIDTH,
  parameter int ADDR_WIDTH = `ACX_NAP_DS_ADDR_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_load,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [MOD_WIDTH-1:0]    i_mod,
  input  logic                    i_sop,
  input  logic                    i_eop,
  input  t_ETH_FLAG_UNION         i_flags,
  input  logic [ETH_TS_WIDTH-1:0] i_timestamp,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    o_can_load,
  t_ETH_STREAM.tx                 if_out
);

  logic                    r_valid;
  logic                    r_sop;
  logic                    r_eop;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [MOD_WIDTH-1:0]    r_mod;
  t_ETH_FLAG_UNION         r_flags;
  logic [ETH_TS_WIDTH-1:0] r_timestamp;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    w_load;

  assign o_can_load = ~r_valid | if_out.ready;
  assign w_load     = i_load & o_can_load;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_data      <= '0;
      r_mod       <= '0;
      r_flags     <= '0;
      r_timestamp <= '0;
      r_addr      <= '0;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_sop       <= i_sop;
      r_eop       <= i_eop;
      r_data      <= i_data;
      r_mod       <= i_mod;
      r_flags     <= i_flags;
      r_timestamp <= i_timestamp;
      r_addr      <= i_addr;
    end else if (if_out.ready) begin
      r_valid <= 1'b0;
    end
  end

  assign if_out.valid     = r_valid;
  assign if_out.sop       = r_sop;
  assign if_out.eop       = r_eop;
  assign if_out.data      = r_data;
  assign if_out.mod       = r_mod;
  assign if_out.flags     = r_flags;
  assign if_out.timestamp = r_timestamp;
  assign if_out.addr      = r_addr;

endmodule

// File: rtl/acx_eth_stream_upsizer.sv
// Narrow-to-NAP-width Ethernet stream upsizer with protocol-error recovery.
// Optional saturating packet/error counters built when ACX_ETH_UPSIZER_STATS_EN is defined.
//   state   | meaning
//   ST_IDLE | no packet open; only an SOP beat is accepted into the accumulator
//   ST_PKT  | packet open; beats pack into lanes until EOP
module acx_eth_stream_upsizer
  import acx_eth_upsizer_pkg::*;
#(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = `ACX_NAP_ETH_DATA_WIDTH,
  parameter int ADDR_WIDTH = `ACX_NAP_DS_ADDR_WIDTH
) (
  input  logic        i_clk,
  input  logic        i_reset,
  t_ETH_STREAM.rx     if_in,
  t_ETH_STREAM.tx     if_out,
  output logic        o_proto_err,
  output logic [31:0] o_pkt_count,
  output logic [15:0] o_err_count
);

  localparam int RATIO     = calc_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int IN_BYTES  = calc_in_bytes(IN_WIDTH);
  localparam int OUT_BYTES = OUT_WIDTH / 8;
  localparam int OUT_MOD_W = `ACX_NAP_ETH_MOD_WIDTH;
  localparam int IDX_W     = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  upsz_state_e             r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [OUT_WIDTH-1:0]    r_acc;
  logic                    r_sop_pend;
  logic [ETH_TS_WIDTH-1:0] r_ts;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_proto_err;

  logic                    w_can_load;
  logic                    w_xfer;
  logic                    w_start;
  logic                    w_accept;
  logic                    w_err;
  logic                    w_complete;
  logic [IDX_W-1:0]        w_lane;
  logic [IN_WIDTH-1:0]     w_beat;
  logic [OUT_WIDTH-1:0]    w_word;
  logic [OUT_MOD_W-1:0]    w_out_mod;
  logic                    w_out_sop;
  logic [ETH_TS_WIDTH-1:0] w_out_ts;
  logic [ADDR_WIDTH-1:0]   w_out_addr;

  assign if_in.ready = w_can_load;

  assign w_xfer     = if_in.valid & w_can_load;
  assign w_start    = w_xfer & if_in.sop;
  assign w_accept   = w_start | (w_xfer & (r_state == ST_PKT));
  assign w_err      = w_xfer & (if_in.sop ? (r_state == ST_PKT) : (r_state == ST_IDLE));
  // A restarting SOP always lands in lane 0, abandoning whatever was accumulated.
  assign w_lane     = w_start ? '0 : r_idx;
  assign w_complete = w_accept & (if_in.eop | (w_lane == LAST_IDX));

  always_comb begin
    w_beat = if_in.data;
    for (int b = 0; b < IN_BYTES; b++) begin
      if (if_in.eop && (if_in.mod != '0) && (b >= int'(if_in.mod))) begin
        w_beat[b*8 +: 8] = 8'h00;
      end
    end
  end

  assign w_word = (w_start ? '0 : r_acc) | (OUT_WIDTH'(w_beat) << (int'(w_lane) * IN_WIDTH));

  assign w_out_mod  = if_in.eop ?
                      OUT_MOD_W'(calc_eop_mod(int'(w_lane), int'(if_in.mod), IN_BYTES, OUT_BYTES)) :
                      '0;
  assign w_out_sop  = w_start | r_sop_pend;
  assign w_out_ts   = w_start ? if_in.timestamp : (r_sop_pend ? r_ts : '0);
  assign w_out_addr = w_start ? ADDR_WIDTH'(if_in.addr) : (r_sop_pend ? r_addr : '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_sop_pend  <= 1'b0;
      r_ts        <= '0;
      r_addr      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_err;
      if (w_start) begin
        r_ts   <= if_in.timestamp;
        r_addr <= ADDR_WIDTH'(if_in.addr);
      end
      if (w_accept) begin
        r_state    <= if_in.eop ? ST_IDLE : ST_PKT;
        r_idx      <= w_complete ? '0 : (w_lane + IDX_W'(1));
        r_acc      <= w_complete ? '0 : w_word;
        r_sop_pend <= ~w_complete & w_out_sop;
      end
    end
  end

  assign o_proto_err = r_proto_err;

  acx_eth_upsizer_oreg #(
    .DATA_WIDTH (OUT_WIDTH),
    .MOD_WIDTH  (OUT_MOD_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_oreg (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_complete),
    .i_data      (w_word),
    .i_mod       (w_out_mod),
    .i_sop       (w_out_sop),
    .i_eop       (if_in.eop),
    .i_flags     (if_in.flags),
    .i_timestamp (w_out_ts),
    .i_addr      (w_out_addr),
    .o_can_load  (w_can_load),
    .if_out      (if_out)
  );

`ifdef ACX_ETH_UPSIZER_STATS_EN
  logic [31:0] r_pkt_count;
  logic [15:0] r_err_count;
  logic        w_eop_out;

  assign w_eop_out = if_out.valid & if_out.ready & if_out.eop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_eop_out && (r_pkt_count != '1)) r_pkt_count <= r_pkt_count + 32'd1;
      if (r_proto_err && (r_err_count != '1)) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_pkt_count = r_pkt_count;
  assign o_err_count = r_err_count;
`else
  assign o_pkt_count = '0;
  assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_acx_eth_stream_upsizer.sv
// Self-checking bench for acx_eth_stream_upsizer (IN_WIDTH=64 -> 256) with a word scoreboard.
module tb_acx_eth_stream_upsizer;
  import acx_eth_upsizer_pkg::*;

  localparam int IN_W  = 64;
  localparam int OUT_W = 256;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [4:0]       mod;
    logic             sop;
    logic             eop;
    logic [7:0]       flags;
    logic [31:0]      ts;
    logic [3:0]       addr;
  } exp_word_t;

  typedef struct {
    int         len;
    logic [31:0] ts;
    logic [3:0]  addr;
    logic [7:0]  eop_flags;
    int         exp_words;
    logic [4:0]  exp_last_mod;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        o_proto_err;
  logic [31:0] o_pkt_count;
  logic [15:0] o_err_count;

  always #5 i_clk = ~i_clk;

  t_ETH_STREAM #(.DATA_WIDTH(IN_W),  .MOD_WIDTH(3)) if_in ();
  t_ETH_STREAM #(.DATA_WIDTH(OUT_W), .MOD_WIDTH(5)) if_out ();

  acx_eth_stream_upsizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .ADDR_WIDTH(4)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .if_in       (if_in),
    .if_out      (if_out),
    .o_proto_err (o_proto_err),
    .o_pkt_count (o_pkt_count),
    .o_err_count (o_err_count)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_word_t   exp_q[$];
  exp_word_t   mon_e;
  logic [7:0]  pkt_bytes [0:1499];
  logic [7:0]  beat_flags [0:187];
  int          words_seen, err_pulses, stall_cycles, pkts_expected;
  logic [4:0]  last_mod_seen;
  logic        last_crc_seen;
  logic [31:0] last_sop_ts;
  logic [3:0]  last_sop_addr;
  logic        rand_ready = 1'b0;
  vec_t        vecs [7];

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor / scoreboard pop, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_proto_err) err_pulses++;
      if (if_in.valid && !if_in.ready) stall_cycles++;
      if (if_out.valid && if_out.ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", OUT_W'(exp_q.size()), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word_data",  if_out.data,      mon_e.data);
          chk("word_mod",   if_out.mod,       mon_e.mod);
          chk("word_sop",   if_out.sop,       mon_e.sop);
          chk("word_eop",   if_out.eop,       mon_e.eop);
          chk("word_flags", if_out.flags,     mon_e.flags);
          chk("word_ts",    if_out.timestamp, mon_e.ts);
          chk("word_addr",  if_out.addr,      mon_e.addr);
        end
        if (if_out.eop) begin
          last_mod_seen = if_out.mod;
          last_crc_seen = if_out.flags.tx.crc_insert;
        end
        if (if_out.sop) begin
          last_sop_ts   = if_out.timestamp;
          last_sop_addr = if_out.addr;
        end
      end
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (rand_ready) if_out.ready = 1'($urandom_range(0, 1));
  end

  task automatic drive_beat(input logic [63:0] d, input logic sop, input logic eop,
                            input logic [2:0] mod, input logic [7:0] fl,
                            input logic [31:0] ts, input logic [3:0] addr);
    bit ok;
    if_in.valid = 1'b1; if_in.data = d; if_in.sop = sop; if_in.eop = eop;
    if_in.mod = mod; if_in.flags = fl; if_in.timestamp = ts; if_in.addr = addr;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge i_clk);
      if (if_in.ready) begin ok = 1'b1; break; end
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    if_in.valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL in_accept_timeout: beat not accepted within 5000 cycles");
    end
  endtask

  task automatic push_expected(input int len, input logic [31:0] ts, input logic [3:0] addr);
    exp_word_t e;
    int nb, nw, lb;
    nb = (len + 7) / 8;
    nw = (nb + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      e.data = '0;
      for (int j = 0; j < 32; j++)
        if (32*w + j < len) e.data[8*j +: 8] = pkt_bytes[32*w + j];
      lb      = (4*w + 3 < nb - 1) ? 4*w + 3 : nb - 1;
      e.flags = beat_flags[lb];
      e.sop   = (w == 0);
      e.eop   = (w == nw - 1);
      e.mod   = e.eop ? 5'(len % 32) : 5'd0;
      e.ts    = e.sop ? ts : 32'd0;
      e.addr  = e.sop ? addr : 4'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_pkt(input int len, input logic [31:0] ts, input logic [3:0] addr,
                          input logic [7:0] eop_flags, input bit gaps);
    int nb;
    logic [63:0] d;
    nb = (len + 7) / 8;
    for (int i = 0; i < len; i++) pkt_bytes[i] = 8'($urandom);
    for (int b = 0; b < nb; b++) beat_flags[b] = 8'($urandom);
    beat_flags[nb-1] = eop_flags;
    push_expected(len, ts, addr);
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++)
        d[8*j +: 8] = (8*b + j < len) ? pkt_bytes[8*b + j] : 8'($urandom);
      if (b == 0)
        drive_beat(d, 1'b1, nb == 1, (nb == 1) ? 3'(len % 8) : 3'd0, beat_flags[b], ts, addr);
      else
        drive_beat(d, 1'b0, b == nb - 1, (b == nb - 1) ? 3'(len % 8) : 3'd0, beat_flags[b],
                   $urandom, 4'($urandom));
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge i_clk); #1; end
    end
    pkts_expected++;
  endtask

  task automatic wait_drain(input int limit);
    for (int c = 0; c < limit; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge i_clk);
    end
    repeat (3) @(posedge i_clk);
    #1;
    chk("scoreboard_drained", OUT_W'(exp_q.size()), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64,  32'h0000_00A1, 4'h1, 8'h00, 2, 5'd0};
    vecs[1] = '{13,  32'h0000_00B2, 4'h2, 8'h01, 1, 5'd13};
    vecs[2] = '{32,  32'h0000_00C3, 4'h3, 8'h00, 1, 5'd0};
    vecs[3] = '{1,   32'h0000_00D4, 4'h4, 8'h01, 1, 5'd1};
    vecs[4] = '{33,  32'h0000_00E5, 4'h5, 8'h80, 2, 5'd1};
    vecs[5] = '{100, 32'h0000_00F6, 4'h6, 8'h01, 4, 5'd4};
    vecs[6] = '{255, 32'h0000_0107, 4'h7, 8'h00, 8, 5'd31};

    i_reset = 1'b1;
    if_in.valid = 1'b0; if_in.data = '0; if_in.sop = 1'b0; if_in.eop = 1'b0;
    if_in.mod = '0; if_in.flags = '0; if_in.timestamp = '0; if_in.addr = '0;
    if_out.ready = 1'b1;
    words_seen = 0; err_pulses = 0; stall_cycles = 0; pkts_expected = 0;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_out_valid", if_out.valid, 0);
    chk("rst_out_sop",   if_out.sop,   0);
    chk("rst_out_eop",   if_out.eop,   0);
    chk("rst_out_data",  if_out.data,  0);
    chk("rst_out_mod",   if_out.mod,   0);
    chk("rst_in_ready",  if_in.ready,  1);
    chk("rst_proto_err", o_proto_err,  0);
    chk("rst_pkt_count", o_pkt_count,  0);
    chk("rst_err_count", o_err_count,  0);
    @(posedge i_clk); #1;

    for (int v = 0; v < 7; v++) begin
      words_seen = 0; stall_cycles = 0;
      send_pkt(vecs[v].len, vecs[v].ts, vecs[v].addr, vecs[v].eop_flags, 1'b0);
      wait_drain(200);
      chk($sformatf("vec%0d_words", v), OUT_W'(words_seen), OUT_W'(vecs[v].exp_words));
      chk($sformatf("vec%0d_last_mod", v), last_mod_seen, vecs[v].exp_last_mod);
      chk($sformatf("vec%0d_in_stalls", v), OUT_W'(stall_cycles), 0);
    end
`ifdef ACX_ETH_UPSIZER_STATS_EN
    chk("pkt_count_table", o_pkt_count, OUT_W'(pkts_expected));
`else
    chk("pkt_count_table_off", o_pkt_count, 0);
`endif

    // SOP into an open packet: partial dropped, one-cycle error pulse, new packet exact.
    err_pulses = 0; words_seen = 0;
    drive_beat(64'h1111_1111_1111_1111, 1'b1, 1'b0, 3'd0, 8'h00, 32'h55, 4'h9);
    drive_beat(64'h2222_2222_2222_2222, 1'b0, 1'b0, 3'd0, 8'h00, 32'h0, 4'h0);
    send_pkt(20, 32'h0000_0777, 4'hA, 8'h01, 1'b0);
    wait_drain(200);
    chk("restart_err_pulses", OUT_W'(err_pulses), 1);
    chk("restart_words", OUT_W'(words_seen), 1);
`ifdef ACX_ETH_UPSIZER_STATS_EN
    chk("restart_err_count", o_err_count, 1);
`endif
    // Beat without SOP while idle: dropped with an error pulse.
    drive_beat(64'h3333_3333_3333_3333, 1'b0, 1'b1, 3'd4, 8'h00, 32'h0, 4'h0);
    wait_drain(50);
    chk("idle_err_pulses", OUT_W'(err_pulses), 2);
    chk("idle_words", OUT_W'(words_seen), 1);
`ifdef ACX_ETH_UPSIZER_STATS_EN
    chk("idle_err_count", o_err_count, 2);
`else
    chk("err_count_off", o_err_count, 0);
`endif

    // Random backpressure, random lengths and input gaps.
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++)
      send_pkt($urandom_range(1, 1500), $urandom, 4'($urandom), 8'($urandom), 1'b1);
    wait_drain(20000);
    rand_ready = 1'b0;
    @(posedge i_clk); #1 if_out.ready = 1'b1;

    // SOP timestamp/addr and EOP crc_insert carried through.
    send_pkt(40, 32'h0123_4567, 4'hF, 8'h01, 1'b0);
    wait_drain(200);
    chk("ts_on_sop",    last_sop_ts,   32'h0123_4567);
    chk("addr_on_sop",  last_sop_addr, 4'hF);
    chk("crc_on_eop",   last_crc_seen, 1);

    // Reset with a full word parked in the output register and a packet open.
    if_out.ready = 1'b0;
    for (int b = 0; b < 4; b++)
      drive_beat({8{8'(b + 1)}}, b == 0, 1'b0, 3'd0, 8'h00, 32'h99, 4'h3);
    @(negedge i_clk);
    chk("parked_valid", if_out.valid, 1);
    @(posedge i_clk); #1 i_reset = 1'b1;
    @(posedge i_clk); #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("midrst_valid", if_out.valid, 0);
    chk("midrst_sop",   if_out.sop,   0);
    chk("midrst_data",  if_out.data,  0);
    chk("midrst_pkt_count", o_pkt_count, 0);
    pkts_expected = 0;
    @(posedge i_clk); #1 if_out.ready = 1'b1;
    words_seen = 0;
    send_pkt(50, 32'h0000_0ABC, 4'h2, 8'h00, 1'b0);
    wait_drain(200);
    chk("postrst_words", OUT_W'(words_seen), 2);
`ifdef ACX_ETH_UPSIZER_STATS_EN
    chk("postrst_pkt_count", o_pkt_count, OUT_W'(pkts_expected));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
